sswfmcw_sweep_seq: RTL and testbench

Chirp sweep sequencer for the SSWFMCW transmitter. It generates the 14-bit phase-increment word that drives the wave-generator phase accumulator, and sequences it through up-ramp, hold, down-ramp (or flyback) and hold segments, with programmable limits, slope and dwell. It replaces the free-running triangle sweep with a start/stop-controlled, frame-counted sweep. It provides a per-frame sync pulse to the receive side.

---
 rtl/sswfmcw_sweep_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_sswfmcw_sweep_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sswfmcw_sweep_seq.sv
//==============================================================================
// Module   : sswfmcw_sweep_seq
// Purpose  : Chirp sweep sequencer for the SSWFMCW transmitter. Produces the
//            14-bit phase-increment word for the wave-generator accumulator and
//            steps it through UP -> HOLD_HI -> DOWN (triangle) or flyback
//            (sawtooth) -> HOLD_LO, frame by frame, under START/STOP control.
// Ports    : CK_i        system clock
//            XARST_i     asynchronous active-low reset
//            START_i     begin sweeping (level sampled, IDLE only)
//            STOP_i      stop at the next frame boundary (level sampled)
//            MODE_i      0 = triangle, 1 = sawtooth
//            ADD_MIN_i   lower increment limit (integer part)
//            ADD_MAX_i   upper increment limit (integer part)
//            STEP_i      slope per clock in 1/4096 increment units
//            HOLD_i      dwell at each end, lasts HOLD_i+1 cycles
//            ADDs_o      phase increment (integer part of accumulator)
//            DN_XUP_o    high in HOLD_HI, DOWN and HOLD_LO
//            SYNC_o      one-cycle pulse on the first UP cycle of each frame
//            BUSY_o      high whenever not IDLE
//            ERR_o       one-cycle pulse on a rejected configuration
//            FRM_CTRs_o  completed-frame count (wraps)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sswfmcw_sweep_seq #(
    parameter int C_HOLD_W = 16,
    parameter int C_FRM_W  = 16
) (
    input  logic                CK_i,
    input  logic                XARST_i,
    input  logic                START_i,
    input  logic                STOP_i,
    input  logic                MODE_i,
    input  logic [13:0]         ADD_MIN_i,
    input  logic [13:0]         ADD_MAX_i,
    input  logic [11:0]         STEP_i,
    input  logic [C_HOLD_W-1:0] HOLD_i,
    output logic [13:0]         ADDs_o,
    output logic                DN_XUP_o,
    output logic                SYNC_o,
    output logic                BUSY_o,
    output logic                ERR_o,
    output logic [C_FRM_W-1:0]  FRM_CTRs_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP      = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_DOWN    = 3'd3,
        ST_HOLD_LO = 3'd4
    } state_t;

    localparam logic [C_HOLD_W-1:0] HOLD_ONE = {{(C_HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [C_FRM_W-1:0]  FRM_ONE  = {{(C_FRM_W-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [25:0]           acc_q, acc_d;       // {14 integer, 12 fraction}
    logic [13:0]           min_q, min_d;
    logic [13:0]           max_q, max_d;
    logic [11:0]           step_q, step_d;
    logic [C_HOLD_W-1:0]   hold_q, hold_d;
    logic                  mode_q, mode_d;
    logic [C_HOLD_W-1:0]   cnt_q, cnt_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  sync_q, sync_d;
    logic                  err_q, err_d;
    logic [C_FRM_W-1:0]    frm_q, frm_d;

    // Compares are done one bit wider than the accumulator so ACC+STEP and
    // MINF+STEP can never wrap.
    logic        cfg_ok;
    logic [26:0] minf, maxf, step27, nxt_up, minf_plus;

    always_comb begin
        cfg_ok    = (ADD_MIN_i < ADD_MAX_i) && (STEP_i != 12'h000);
        minf      = {1'b0, min_q, 12'h000};
        maxf      = {1'b0, max_q, 12'h000};
        step27    = {15'h0000, step_q};
        nxt_up    = {1'b0, acc_q} + step27;
        minf_plus = minf + step27;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        min_d       = min_q;
        max_d       = max_q;
        step_d      = step_q;
        hold_d      = hold_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;
        sync_d      = 1'b0;
        err_d       = 1'b0;
        frm_d       = frm_q;

        if (state_q != ST_IDLE && STOP_i) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                acc_d       = 26'd0;
                stop_pend_d = 1'b0;
                if (START_i) begin
                    if (cfg_ok) begin
                        min_d   = ADD_MIN_i;
                        max_d   = ADD_MAX_i;
                        step_d  = STEP_i;
                        hold_d  = HOLD_i;
                        mode_d  = MODE_i;
                        acc_d   = {ADD_MIN_i, 12'h000};
                        state_d = ST_UP;
                        sync_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_UP: begin
                if (nxt_up >= maxf) begin
                    acc_d   = maxf[25:0];
                    cnt_d   = hold_q;
                    state_d = ST_HOLD_HI;
                end else begin
                    acc_d = nxt_up[25:0];
                end
            end

            ST_HOLD_HI: begin
                if (cnt_q == '0) begin
                    if (mode_q) begin
                        // Sawtooth flyback: jump straight to the low limit.
                        acc_d   = minf[25:0];
                        cnt_d   = hold_q;
                        state_d = ST_HOLD_LO;
                    end else begin
                        state_d = ST_DOWN;
                    end
                end else begin
                    cnt_d = cnt_q - HOLD_ONE;
                end
            end

            ST_DOWN: begin
                if ({1'b0, acc_q} <= minf_plus) begin
                    acc_d   = minf[25:0];
                    cnt_d   = hold_q;
                    state_d = ST_HOLD_LO;
                end else begin
                    acc_d = acc_q - {14'h0000, step_q};
                end
            end

            ST_HOLD_LO: begin
                if (cnt_q == '0) begin
                    // Frame boundary: count it, then stop or restart.
                    frm_d = frm_q + FRM_ONE;
                    if (stop_pend_q || STOP_i) begin
                        state_d     = ST_IDLE;
                        acc_d       = 26'd0;
                        stop_pend_d = 1'b0;
                    end else begin
                        min_d  = ADD_MIN_i;
                        max_d  = ADD_MAX_i;
                        step_d = STEP_i;
                        hold_d = HOLD_i;
                        mode_d = MODE_i;
                        if (cfg_ok) begin
                            acc_d   = {ADD_MIN_i, 12'h000};
                            state_d = ST_UP;
                            sync_d  = 1'b1;
                        end else begin
                            state_d     = ST_IDLE;
                            acc_d       = 26'd0;
                            stop_pend_d = 1'b0;
                            err_d       = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - HOLD_ONE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                acc_d       = 26'd0;
                stop_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q     <= ST_IDLE;
            acc_q       <= 26'd0;
            min_q       <= 14'd0;
            max_q       <= 14'd0;
            step_q      <= 12'd0;
            hold_q      <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            sync_q      <= 1'b0;
            err_q       <= 1'b0;
            frm_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            min_q       <= min_d;
            max_q       <= max_d;
            step_q      <= step_d;
            hold_q      <= hold_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            sync_q      <= sync_d;
            err_q       <= err_d;
            frm_q       <= frm_d;
        end
    end

    // Outputs are direct decodes of registered state.
    assign ADDs_o     = acc_q[25:12];
    assign DN_XUP_o   = (state_q == ST_HOLD_HI) || (state_q == ST_DOWN) ||
                        (state_q == ST_HOLD_LO);
    assign BUSY_o     = (state_q != ST_IDLE);
    assign SYNC_o     = sync_q;
    assign ERR_o      = err_q;
    assign FRM_CTRs_o = frm_q;

endmodule

`default_nettype wire

// File: tb/tb_sswfmcw_sweep_seq.sv
//==============================================================================
// Module   : tb_sswfmcw_sweep_seq
// Purpose  : Self-checking bench for sswfmcw_sweep_seq. Stimulus pushes
//            cycle-tagged expected outputs into a queue; a monitor compares
//            them on the falling edge of the matching cycle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sswfmcw_sweep_seq;

    logic        clk;
    logic        rst_n;
    logic        start, stop, mode;
    logic [13:0] add_min, add_max;
    logic [11:0] step;
    logic [15:0] hold;
    logic [13:0] adds;
    logic        dn_xup, sync, busy, err;
    logic [15:0] frm;

    sswfmcw_sweep_seq #(.C_HOLD_W(16), .C_FRM_W(16)) dut (
        .CK_i       (clk),
        .XARST_i    (rst_n),
        .START_i    (start),
        .STOP_i     (stop),
        .MODE_i     (mode),
        .ADD_MIN_i  (add_min),
        .ADD_MAX_i  (add_max),
        .STEP_i     (step),
        .HOLD_i     (hold),
        .ADDs_o     (adds),
        .DN_XUP_o   (dn_xup),
        .SYNC_o     (sync),
        .BUSY_o     (busy),
        .ERR_o      (err),
        .FRM_CTRs_o (frm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       nm;
        logic [33:0] v;   // {adds, dn, sync, busy, err, frm}
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Hand-computed ADDs_o per frame cycle (MIN=100, STEP=0x800, HOLD=1).
    int TRI_A [12] = '{100,100,101,101,102,102,102,101,101,100,100,100};
    int SAW_A [8]  = '{100,100,101,101,102,102,100,100};
    int BIG_A [20] = '{100,100,101,101,102,102,103,103,104,104,
                       104,103,103,102,102,101,101,100,100,100};

    task automatic push(input int dly, input string nm, input logic [13:0] a,
                        input logic d, input logic s, input logic b,
                        input logic e, input logic [15:0] f);
        exp_t x;
        x.cyc = cyc + dly;
        x.nm  = nm;
        x.v   = {a, d, s, b, e, f};
        q.push_back(x);
    endtask

    // kind: 0 triangle, 1 sawtooth, 2 triangle peaking at 104
    task automatic push_frame(input int d0, input int kind, input int n,
                              input logic [15:0] f, input string nm);
        int a;
        int up;
        up = (kind == 2) ? 8 : 4;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0:       a = TRI_A[i];
                1:       a = SAW_A[i];
                default: a = BIG_A[i];
            endcase
            push(d0 + i, $sformatf("%s[%0d]", nm, i), a[13:0], (i >= up),
                 (i == 0), 1'b1, 1'b0, f);
        end
    endtask

    task automatic push_idle(input int d0, input int n, input logic [15:0] f,
                             input string nm);
        for (int i = 0; i < n; i++)
            push(d0 + i, $sformatf("%s[%0d]", nm, i), 14'd0, 1'b0, 1'b0,
                 1'b0, 1'b0, f);
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step_clk();
    endtask

    // Monitor: compare every expectation tagged with the current cycle.
    initial begin
        exp_t        x;
        logic [33:0] got;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                x = q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                         x.nm, x.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                x   = q.pop_front();
                got = {adds, dn_xup, sync, busy, err, frm};
                checks++;
                if (got !== x.v) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got adds=%0d dn=%b sync=%b busy=%b err=%b frm=%0d exp adds=%0d dn=%b sync=%b busy=%b err=%b frm=%0d",
                             x.nm, cyc, got[33:20], got[19], got[18], got[17],
                             got[16], got[15:0], x.v[33:20], x.v[19], x.v[18],
                             x.v[17], x.v[16], x.v[15:0]);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 1'b0;
        add_min = 14'd100;
        add_max = 14'd102;
        step    = 12'h800;
        hold    = 16'd1;

        // Reset values, during and after reset.
        push_idle(1, 2, 16'd0, "rst_hold");
        run(2);
        rst_n = 1'b1;
        push_idle(1, 2, 16'd0, "rst_rel");
        run(2);

        // Triangle: two 12-cycle frames, stop requested during frame 1.
        start = 1'b1;
        push_frame(1, 0, 12, 16'd0, "tri0");
        push_frame(13, 0, 12, 16'd1, "tri1");
        push_idle(25, 2, 16'd2, "tri_end");
        step_clk();
        start = 1'b0;
        run(13);
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        run(12);

        // Sawtooth with stop in UP of frame 0: one 8-cycle frame then IDLE.
        mode  = 1'b1;
        start = 1'b1;
        push_frame(1, 1, 8, 16'd2, "saw0");
        push_idle(9, 3, 16'd3, "saw_end");
        step_clk();
        start = 1'b0;
        stop  = 1'b1;
        step_clk();
        stop  = 1'b0;
        run(10);
        mode  = 1'b0;

        // Rejected starts: MIN == MAX, then STEP == 0.
        add_min = 14'd200;
        add_max = 14'd200;
        start   = 1'b1;
        push(1, "err_eq", 14'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
        push(2, "err_eq_clr", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
        step_clk();
        start = 1'b0;
        step_clk();
        add_min = 14'd100;
        add_max = 14'd102;
        step    = 12'h000;
        start   = 1'b1;
        push(1, "err_step", 14'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
        push(2, "err_step_clr", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
        step_clk();
        start = 1'b0;
        step_clk();
        step = 12'h800;

        // ADD_MAX_i changed mid-frame: takes effect only on the next frame.
        start = 1'b1;
        push_frame(1, 0, 12, 16'd3, "max0");
        push_frame(13, 2, 20, 16'd4, "max1");
        push_idle(33, 2, 16'd5, "max_end");
        step_clk();
        start = 1'b0;
        run(2);
        add_max = 14'd104;
        run(12);
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        run(19);
        add_max = 14'd102;

        // Asynchronous reset during DOWN, then a fresh sweep.
        start = 1'b1;
        push_frame(1, 0, 7, 16'd5, "pre_rst");
        step_clk();
        start = 1'b0;
        run(7);
        rst_n = 1'b0;
        push_idle(0, 3, 16'd0, "async_rst");
        run(2);
        rst_n = 1'b1;
        push_idle(1, 3, 16'd0, "post_rst");
        run(3);
        start = 1'b1;
        push_frame(1, 0, 12, 16'd0, "new0");
        push_idle(13, 2, 16'd1, "new_end");
        step_clk();
        start = 1'b0;
        stop  = 1'b1;
        step_clk();
        stop  = 1'b0;
        run(13);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
